dff_ram_4x72: RTL and testbench



---
 rtl/dff_ram_pkg.sv | 42 ++++
 rtl/dff_ram_word.sv | 26 ++
 rtl/dff_ram_4x72.sv | 74 +++++++
 tb/tb_dff_ram_4x72.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dff_ram_pkg.sv
// Shared widths, types and helpers for the 4x72 flip-flop RAM.
// DFF_RAM_PARITY_EN adds one even-parity bit to every stored row.
package dff_ram_pkg;

   localparam int unsigned DATA_W = 72;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = $clog2(DEPTH);

`ifdef DFF_RAM_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif

   // One storage row: data plus optional parity bit in the MSB.
   localparam int unsigned ROW_W = DATA_W + PAR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_READ,
      OP_WRITE
   } op_t;

   // en_n gates the whole access; wr only matters when enabled.
   function automatic op_t decode_op(input logic en_n, input logic wr);
      op_t op;
      op = OP_IDLE;
      if (!en_n) begin
         op = wr ? OP_WRITE : OP_READ;
      end
      return op;
   endfunction

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic even_parity(input data_t d);
      return ^d;
   endfunction

endpackage

// File: rtl/dff_ram_word.sv
// One resettable storage row with write enable.
module dff_ram_word
   import dff_ram_pkg::*;
#(
   parameter int unsigned WORD_W = ROW_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   logic [WORD_W-1:0] row_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_r <= '0;
      end else if (we) begin
         row_r <= d;
      end
   end

   assign q = row_r;

endmodule

// File: rtl/dff_ram_4x72.sv
// 4 x 72 single-port flip-flop RAM, synchronous write, registered 1-cycle read.
// Define DFF_RAM_PARITY_EN for per-word even parity and the parity_err output.
module dff_ram_4x72
   import dff_ram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              en_n,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
`ifdef DFF_RAM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   op_t               op_c;
   logic [DEPTH-1:0]  we_c;
   logic [ROW_W-1:0]  wrow_c;
   logic [ROW_W-1:0]  rrow_c;
   logic [ROW_W-1:0]  row_q [DEPTH];

   assign op_c = decode_op(en_n, wr);

   // Address decode: exactly one row enabled on a write, none otherwise.
   always_comb begin
      we_c = '0;
      if (op_c == OP_WRITE) begin
         we_c[address] = 1'b1;
      end
   end

`ifdef DFF_RAM_PARITY_EN
   assign wrow_c = {even_parity(wdata), wdata};
`else
   assign wrow_c = wdata;
`endif

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_row
      dff_ram_word #(
         .WORD_W (ROW_W)
      ) u_row (
         .clk (clk),
         .rst (rst),
         .we  (we_c[g]),
         .d   (wrow_c),
         .q   (row_q[g])
      );
   end

   assign rrow_c = row_q[address];

   // Read register: loads only on a read, holds through idle and write cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (op_c == OP_READ) begin
         rdata <= rrow_c[DATA_W-1:0];
      end
   end

`ifdef DFF_RAM_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else if (op_c == OP_READ) begin
         parity_err <= even_parity(rrow_c[DATA_W-1:0]) != rrow_c[DATA_W];
      end
   end
`endif

endmodule

// File: tb/tb_dff_ram_4x72.sv
// Self-checking bench for dff_ram_4x72: directed vector table, reset/parity
// sequences and a randomized run against a behavioural memory model.
module tb_dff_ram_4x72;

   localparam int unsigned DW = 72;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    address;
   logic          en_n;
   logic          wr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
`ifdef DFF_RAM_PARITY_EN
   logic          parity_err;
`endif

   always #5 clk = ~clk;

   dff_ram_4x72 dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .en_n       (en_n),
      .wr         (wr),
      .wdata      (wdata),
      .rdata      (rdata)
`ifdef DFF_RAM_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: an array of words and the last value read out.
   logic [DW-1:0] m_mem [4];
   logic [DW-1:0] m_rdata;

   typedef struct {
      logic          rst;
      logic          en_n;
      logic          wr;
      logic [1:0]    addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   localparam int unsigned NVEC = 18;
   vec_t tbl [NVEC];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic r, input logic e, input logic w,
                       input logic [1:0] a, input logic [DW-1:0] d);
      rst     = r;
      en_n    = e;
      wr      = w;
      address = a;
      wdata   = d;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 4; i++) m_mem[i] = '0;
         m_rdata = '0;
      end else if (!e && !w) begin
         m_rdata = m_mem[a];
      end else if (!e && w) begin
         m_mem[a] = d;
      end
      #1;
   endtask

   initial begin
      logic [DW-1:0] v_aa;
      logic [DW-1:0] v_55;
      logic [DW-1:0] v_ff;
      logic [DW-1:0] v_mix;
      v_aa  = 72'hAAAAAAAAAAAAAAAAAA;
      v_55  = 72'h555555555555555555;
      v_ff  = 72'hFFFFFFFFFFFFFFFFFF;
      v_mix = 72'h123456789ABCDEF012;

      tbl[0]  = '{rst:1'b1, en_n:1'b1, wr:1'b0, addr:2'd0, wdata:'0,         exp:'0};
      tbl[1]  = '{rst:1'b1, en_n:1'b1, wr:1'b0, addr:2'd0, wdata:'0,         exp:'0};
      tbl[2]  = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd0, wdata:'0,         exp:'0};
      tbl[3]  = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd1, wdata:'0,         exp:'0};
      tbl[4]  = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd2, wdata:'0,         exp:'0};
      tbl[5]  = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd3, wdata:'0,         exp:'0};
      tbl[6]  = '{rst:1'b0, en_n:1'b0, wr:1'b1, addr:2'd0, wdata:72'h1,      exp:'0};
      tbl[7]  = '{rst:1'b0, en_n:1'b0, wr:1'b1, addr:2'd1, wdata:v_aa,       exp:'0};
      tbl[8]  = '{rst:1'b0, en_n:1'b0, wr:1'b1, addr:2'd2, wdata:v_55,       exp:'0};
      tbl[9]  = '{rst:1'b0, en_n:1'b0, wr:1'b1, addr:2'd3, wdata:v_ff,       exp:'0};
      tbl[10] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd0, wdata:'0,         exp:72'h1};
      tbl[11] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd1, wdata:'0,         exp:v_aa};
      tbl[12] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd2, wdata:'0,         exp:v_55};
      tbl[13] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd3, wdata:'0,         exp:v_ff};
      tbl[14] = '{rst:1'b0, en_n:1'b0, wr:1'b1, addr:2'd2, wdata:v_mix,      exp:v_ff};
      tbl[15] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd2, wdata:'0,         exp:v_mix};
      tbl[16] = '{rst:1'b0, en_n:1'b1, wr:1'b1, addr:2'd1, wdata:72'hDEAD,   exp:v_mix};
      tbl[17] = '{rst:1'b0, en_n:1'b0, wr:1'b0, addr:2'd1, wdata:'0,         exp:v_aa};

      for (int i = 0; i < int'(NVEC); i++) begin
         step(tbl[i].rst, tbl[i].en_n, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
         check($sformatf("vec%0d", i), rdata, tbl[i].exp);
      end

      // Reset after writes wipes every word; the access in the reset cycle is dropped.
      step(1'b0, 1'b0, 1'b1, 2'd1, 72'hBEEF);
      step(1'b0, 1'b0, 1'b0, 2'd1, '0);
      check("pre_rst_read", rdata, 72'hBEEF);
      step(1'b1, 1'b0, 1'b1, 2'd2, 72'hCAFE);
      check("rst_clears_rdata", rdata, '0);
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 1'b0, 1'b0, 2'(a), '0);
         check($sformatf("post_rst_addr%0d", a), rdata, '0);
      end

`ifdef DFF_RAM_PARITY_EN
      // Corrupt one stored data bit of addr3 while leaving its parity bit alone.
      step(1'b0, 1'b0, 1'b1, 2'd3, 72'hF0);
      step(1'b0, 1'b0, 1'b0, 2'd3, '0);
      check("par_clean", DW'(parity_err), '0);
      force dut.g_row[3].u_row.row_r = {1'b0, 72'hF1};
      step(1'b0, 1'b0, 1'b0, 2'd3, '0);
      check("par_flip_err", DW'(parity_err), DW'(1));
      check("par_flip_data", rdata, 72'hF1);
      step(1'b0, 1'b0, 1'b0, 2'd0, '0);
      check("par_clean_word", DW'(parity_err), '0);
      release dut.g_row[3].u_row.row_r;
      step(1'b0, 1'b0, 1'b1, 2'd3, 72'hF0);
`endif

      // Randomized traffic against the model, with occasional resets.
      for (int c = 0; c < 50; c++) begin
         logic          r_rst;
         logic          r_en_n;
         logic          r_wr;
         logic [1:0]    r_addr;
         logic [DW-1:0] r_data;
         r_rst  = ($urandom_range(0, 24) == 0);
         r_en_n = ($urandom_range(0, 3) == 0);
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = 2'($urandom_range(0, 3));
         r_data = {8'($urandom), $urandom, $urandom};
         step(r_rst, r_en_n, r_wr, r_addr, r_data);
         check($sformatf("rand%0d", c), rdata, m_rdata);
`ifdef DFF_RAM_PARITY_EN
         check($sformatf("rand_par%0d", c), DW'(parity_err), '0);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
